// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the multi-channel cache-to-memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned IOSTATEWIDTH = 2;
    localparam int unsigned ADDRWIDTH    = 16;
    localparam int unsigned WORDWIDTH    = 16;
    localparam int unsigned ERRWIDTH     = 4;

    // Per-channel operation codes; 2'b11 is the illegal code.
    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'b00;
    localparam logic [IOSTATEWIDTH-1:0] RD   = 2'b01;
    localparam logic [IOSTATEWIDTH-1:0] WT   = 2'b10;

    // Sticky error bit positions in errReg.
    localparam int unsigned ERR_ILLEGAL = 0;
    localparam int unsigned ERR_RANGE   = 1;

    // Access latency counter width (LATENCY up to 255).
    localparam int unsigned CNTWIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One captured cache request.
    typedef struct packed {
        logic [IOSTATEWIDTH-1:0] rw;
        logic [ADDRWIDTH-1:0]    addr;
        logic [WORDWIDTH-1:0]    data;
    } mem_req_t;

    // True for the two operation codes the memory understands.
    function automatic logic rw_legal(input logic [IOSTATEWIDTH-1:0] rw);
        return (rw == RD) || (rw == WT);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr (mod NCH).
module rr_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic           valid
);

    logic [PW-1:0] idx;

    // Scan channels starting at the pointer; the first requester wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = PW'((32'(ptr) + k) % NCH);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter of NCH cache ports onto one word-addressed backing memory.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned LATENCY  = 100,
    parameter int unsigned MEMWORDS = 65536
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCH*IOSTATEWIDTH-1:0] rwFromCache,
    input  logic [NCH*ADDRWIDTH-1:0]    addrFromCache,
    input  logic [NCH*WORDWIDTH-1:0]    dataFromCache,
    output logic [WORDWIDTH-1:0]        dataToCache,
    output logic [NCH-1:0]              doneToCache,
    output logic [NCH-1:0]              grantToCache,
    output logic [ERRWIDTH-1:0]         errReg
);

    localparam int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AIW = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;

    state_t               state;
    logic [CNTWIDTH-1:0]  cnt;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        gidx;
    mem_req_t             req_q;

    logic [NCH-1:0]       req_c;
    logic [NCH-1:0]       arb_grant_c;
    logic                 arb_valid_c;
    logic [PW-1:0]        arb_idx_c;
    mem_req_t             sel_c;
    logic [AIW-1:0]       mem_idx_c;
    logic [WORDWIDTH-1:0] rd_data_c;

    logic [WORDWIDTH-1:0] mem [MEMWORDS];

    function automatic logic in_range(input logic [ADDRWIDTH-1:0] a);
        return 32'(a) < MEMWORDS;
    endfunction

    // A channel requests whenever its op code is not IDEL.
    always_comb begin
        req_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            req_c[i] = (rwFromCache[i*IOSTATEWIDTH +: IOSTATEWIDTH] != IDEL);
        end
    end

    rr_arbiter #(
        .NCH (NCH),
        .PW  (PW)
    ) u_rr (
        .req   (req_c),
        .ptr   (ptr),
        .grant (arb_grant_c),
        .valid (arb_valid_c)
    );

    // Mux out the winning channel's index and request fields.
    always_comb begin
        arb_idx_c = '0;
        sel_c     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (arb_grant_c[i]) begin
                arb_idx_c  = PW'(i);
                sel_c.rw   = rwFromCache[i*IOSTATEWIDTH +: IOSTATEWIDTH];
                sel_c.addr = addrFromCache[i*ADDRWIDTH +: ADDRWIDTH];
                sel_c.data = dataFromCache[i*WORDWIDTH +: WORDWIDTH];
            end
        end
    end

    assign mem_idx_c = req_q.addr[AIW-1:0];

    // Read result: illegal ops and out-of-range addresses return zero.
    always_comb begin
        rd_data_c = '0;
        if ((req_q.rw == RD) && in_range(req_q.addr)) begin
            rd_data_c = mem[mem_idx_c];
        end
    end

    // Backing store write at the end of a legal in-range write; never reset.
    always_ff @(posedge clk) begin
        if ((state == ST_BUSY) && (cnt == '0) && (req_q.rw == WT) && in_range(req_q.addr)) begin
            mem[mem_idx_c] <= req_q.data;
        end
    end

    // Access FSM: arbitrate in IDLE, count latency in BUSY, pulse done in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ptr          <= '0;
            gidx         <= '0;
            req_q        <= '0;
            dataToCache  <= '0;
            doneToCache  <= '0;
            grantToCache <= '0;
            errReg       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid_c) begin
                        req_q        <= sel_c;
                        gidx         <= arb_idx_c;
                        grantToCache <= arb_grant_c;
                        cnt          <= CNTWIDTH'(LATENCY - 1);
                        if (!rw_legal(sel_c.rw)) begin
                            errReg[ERR_ILLEGAL] <= 1'b1;
                        end
                        if (!in_range(sel_c.addr)) begin
                            errReg[ERR_RANGE] <= 1'b1;
                        end
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNTWIDTH'(1);
                    end else begin
                        if (req_q.rw != WT) begin
                            dataToCache <= rd_data_c;
                        end
                        doneToCache <= grantToCache;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    doneToCache  <= '0;
                    grantToCache <= '0;
                    ptr          <= (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
